// File: rtl/sync_ufifo_pkg.sv
// Shared sizing helpers and default typedefs for the single-clock micro FIFO.
// Pointer and level widths are derived from depth so every file agrees on them.
package sync_ufifo_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int ptr_bits(input int depth);
        return clog2(depth);
    endfunction

    // Level must hold the value depth itself, hence depth+1 states.
    function automatic int lvl_bits(input int depth);
        return clog2(depth + 1);
    endfunction

    localparam int DEF_DEPTH = 4;
    typedef logic [ptr_bits(DEF_DEPTH)-1:0] def_ptr_t;
    typedef logic [lvl_bits(DEF_DEPTH)-1:0] def_lvl_t;

    // {wr_en, rd_en} transfer class used by the level counter.
    typedef enum logic [1:0] {
        XFER_IDLE = 2'b00,
        XFER_RD   = 2'b01,
        XFER_WR   = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

endpackage

// File: rtl/sync_ufifo_if.sv
// Producer/consumer bundle of the micro FIFO; master is the user side, slave is the FIFO.
// Widths follow lpm_width and lpm_depth, which must match the attached sync_ufifo.
interface sync_ufifo_if
    import sync_ufifo_pkg::*;
#(
    parameter int lpm_width = 8,
    parameter int lpm_depth = 4
) ();

    localparam int lvl_w = lvl_bits(lpm_depth);

    logic [lpm_width-1:0] d;
    logic                 denable;
    logic                 full;
    logic [lpm_width-1:0] q;
    logic                 qenable;
    logic                 ready;
    logic [lvl_w-1:0]     level;
    logic                 afull;
    logic                 aempty;
    logic                 clr_err;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output d, denable, qenable, clr_err,
        input  full, q, ready, level, afull, aempty, overflow, underflow
    );

    modport slave (
        input  d, denable, qenable, clr_err,
        output full, q, ready, level, afull, aempty, overflow, underflow
    );

endinterface

// File: rtl/sync_ufifo_ptr.sv
// ufifo_ptr: wrapping pointer counter; advances one slot per cycle with inc high.
// Latency 1 cycle; no back-pressure of its own, the caller gates inc.
module ufifo_ptr #(
    parameter int ptr_w = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [ptr_w-1:0] ptr
);

    // Depth is a power of two, so plain binary overflow is the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sync_ufifo.sv
// sync_ufifo: single-clock FWFT micro FIFO with level/almost flags; sticky errors when SYNC_UFIFO_ERR_EN is defined.
// Latency 1 cycle write-to-q; back-pressure via full (writes dropped) and ready (reads ignored).
module sync_ufifo
    import sync_ufifo_pkg::*;
#(
    parameter int lpm_width  = 8,
    parameter int lpm_depth  = 4,
    parameter int afull_lvl  = 3,
    parameter int aempty_lvl = 1
) (
    input  logic         clk,
    input  logic         reset,
    sync_ufifo_if.slave  bus
);

    localparam int ptr_w = ptr_bits(lpm_depth);
    localparam int lvl_w = lvl_bits(lpm_depth);

    typedef logic [ptr_w-1:0]     ptr_t;
    typedef logic [lvl_w-1:0]     lvl_t;
    typedef logic [lpm_width-1:0] word_t;

    localparam lvl_t depth_lvl  = lvl_t'(lpm_depth);
    localparam lvl_t afull_thr  = lvl_t'(afull_lvl);
    localparam lvl_t aempty_thr = lvl_t'(aempty_lvl);

    generate
        if (lpm_width < 1) begin : g_bad_width
            $error("sync_ufifo: lpm_width must be >= 1");
        end
        if (lpm_depth < 2 || (lpm_depth & (lpm_depth - 1)) != 0) begin : g_bad_depth
            $error("sync_ufifo: lpm_depth must be a power of two >= 2");
        end
        if (afull_lvl < 1 || afull_lvl > lpm_depth) begin : g_bad_afull
            $error("sync_ufifo: afull_lvl must be in 1..lpm_depth");
        end
        if (aempty_lvl < 0 || aempty_lvl > lpm_depth - 1) begin : g_bad_aempty
            $error("sync_ufifo: aempty_lvl must be in 0..lpm_depth-1");
        end
    endgenerate

    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    lvl_t  level_r;
    word_t mem [lpm_depth];
    logic  wr_en;
    logic  rd_en;
    xfer_e xfer;

    // Status depends only on the registered level, never on this cycle's requests.
    assign bus.full   = (level_r == depth_lvl);
    assign bus.ready  = (level_r != '0);
    assign bus.afull  = (level_r >= afull_thr);
    assign bus.aempty = (level_r <= aempty_thr);
    assign bus.level  = level_r;
    assign bus.q      = mem[rd_ptr];

    assign wr_en = bus.denable & ~bus.full;
    assign rd_en = bus.qenable & bus.ready;
    assign xfer  = xfer_e'({wr_en, rd_en});

    ufifo_ptr #(.ptr_w(ptr_w)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    ufifo_ptr #(.ptr_w(ptr_w)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < lpm_depth; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= bus.d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= '0;
        end else begin
            case (xfer)
                XFER_WR: level_r <= level_r + 1'b1;
                XFER_RD: level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

`ifdef SYNC_UFIFO_ERR_EN
    logic ovf_r;
    logic unf_r;

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (bus.denable & bus.full) begin
                ovf_r <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_r <= 1'b0;
            end
            if (bus.qenable & ~bus.ready) begin
                unf_r <= 1'b1;
            end else if (bus.clr_err) begin
                unf_r <= 1'b0;
            end
        end
    end

    assign bus.overflow  = ovf_r;
    assign bus.underflow = unf_r;
`else
    logic unused_clr_err;
    assign unused_clr_err = bus.clr_err;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

endmodule

// File: doc/sync_ufifo.md
# sync_ufifo

Single-clock, parametrised micro FIFO: the same-clock successor to the team's clock-domain-crossing micro FIFO. It buffers up to `lpm_depth` words with first-word-fall-through output, and reports fill level, almost-full/almost-empty and optional sticky error flags. It sits between same-clock producer/consumer stages wherever a small elastic buffer with back-pressure status is needed.

## Interface
Parameters:
- `lpm_width`, default 8: data word width, ≥1.
- `lpm_depth`, default 4: number of storage words; power of two, ≥2.
- `afull_lvl`, default 3: `afull` asserts when level ≥ this value; legal range 1..`lpm_depth`.
- `aempty_lvl`, default 1: `aempty` asserts when level ≤ this value; legal range 0..`lpm_depth`-1.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `d`, in, `lpm_width`: write data.
- `denable`, in, 1: write request.
- `full`, out, 1: level == `lpm_depth`.
- `q`, out, `lpm_width`: head-of-FIFO data (FWFT).
- `qenable`, in, 1: read acknowledge; pops the head.
- `ready`, out, 1: level != 0, so `q` is valid.
- `level`, out, clog2(`lpm_depth`+1): current word count.
- `afull`, out, 1: almost full.
- `aempty`, out, 1: almost empty.
- `clr_err`, in, 1: clears sticky error flags.
- `overflow`, out, 1: sticky write-while-full flag.
- `underflow`, out, 1: sticky read-while-empty flag.

## Operation
- Write accepted (`wr_en`) = `denable` & !`full`. On acceptance, `d` is stored at `wr_ptr` and `wr_ptr` increments.
- Read accepted (`rd_en`) = `qenable` & `ready`. On acceptance, `rd_ptr` increments.
- Pointers are clog2(`lpm_depth`) bits wide and wrap naturally from `lpm_depth`-1 to 0.
- Level update: `level` ← `level` + `wr_en` − `rd_en`.
  - Both accepted: level unchanged; both pointers advance.
- At full with `denable` and `qenable` both high, only the read is accepted. There is no pass-through write at full.
- At empty with both requests high, only the write is accepted (`ready` is 0).
- `q` = `buf[rd_ptr]`, a combinational mux from registers. `q` is meaningful only while `ready` = 1.
- `full`, `ready`, `afull` and `aempty` are decoded combinationally from the registered `level` only. They do not depend on the current-cycle requests.
- Reset values:
  - pointers, `level`, storage, `overflow`, `underflow` = 0.
  - Therefore `q` = 0, `ready` = 0, `full` = 0, `afull` = 0, `aempty` = 1.
- Reset asserted mid-operation discards all contents at that edge. Any requests in that cycle are ignored.

## Timing
- Write-to-read latency is 1 cycle: a word written at edge n is visible on `q`, with `ready` = 1, after edge n.
- A read at edge n presents the next word on `q` after edge n.
- `level` and all flags update at the same edge as the accepted transfer.
- Sustained throughput is one write and one read per cycle when 0 < level < `lpm_depth`.

## Configuration
- Macro `SYNC_UFIFO_ERR_EN`.
- Defined:
  - `overflow` is set at the edge where `denable` & `full`.
  - `underflow` is set at the edge where `qenable` & !`ready`.
  - Both flags are sticky until `reset`, or until an edge with `clr_err` = 1.
  - If `clr_err` and a new error occur in the same cycle, set wins.
- Not defined: `overflow` and `underflow` are tied to 0 and `clr_err` is ignored. The port list is identical in both builds.

## Structure
- Package `sync_ufifo_pkg`:
  - `clog2` constant function.
  - Parametrised typedefs for pointer and level, derived from depth.
- One sub-module `ufifo_ptr`: wrapping pointer counter with `clk`, `reset`, `inc` and `ptr` ports. It is instantiated once for read and once for write.
- Storage and the level counter live in the top module.
- The top module carries elaboration-time assertions on the parameter legality rules above.

## Test plan
All scenarios use `lpm_depth` = 4, `afull_lvl` = 3, `aempty_lvl` = 1.
1. Reset, then idle → `level` = 0, `ready` = 0, `aempty` = 1, `q` = 0. Single write of 0xA5 → next cycle `ready` = 1, `q` = 0xA5, `level` = 1.
2. Write 0x11, 0x22, 0x33, 0x44 back-to-back → `afull` = 1 at level 3, `full` = 1 at level 4. A fifth write of 0x55 is dropped; with macro, `overflow` = 1. Four reads return 0x11..0x44 in order.
3. Fill to 4, then hold `denable` and `qenable` high for 1 cycle → only the read is accepted: `level` = 3, `full` = 0, head becomes 0x22.
4. At level 2, sustain simultaneous write and read for 10 cycles → `level` stays 2; output order matches input order across pointer wrap.
5. `qenable` while empty → nothing is popped; with macro, `underflow` = 1. Pulse `clr_err` → flag clears next edge. `clr_err` coincident with a new underflow → flag stays 1.
6. Assert `reset` at level 3 while `denable` = 1 → after the edge `level` = 0, `ready` = 0, the write is discarded, and error flags are 0.
